mux_tree_pipe: RTL

Pipelined, word-wide 2^N-to-1 selector for the auction datapath. It picks one W-bit entry from a flat bus of 2^N entries under a binary select. The reduction tree is split into register stages of K levels each, with valid/ready flow control at both ends. Each result is returned with its select index and the one-hot decode of that index, so downstream bid/winner logic needs no separate decoder.

---
 rtl/mux_tree_pipe_pkg.sv | 22 ++
 rtl/mux_tree_level.sv | 21 ++
 rtl/mux_tree_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: stage sizing macro and level-range functions.
// No logic, compile-time only.
// Imported by the tree top; the macro is visible to every file compiled after this one.
`ifndef CEIL_DIV
`define CEIL_DIV(a, b) (((a) + (b) - 1) / (b))
`endif

package mux_tree_pipe_pkg;

  // First tree level handled by register stage s.
  function automatic int stage_lo(input int s, input int k);
    return s * k;
  endfunction

  // One past the last tree level handled by register stage s (the last stage may be short).
  function automatic int stage_hi(input int s, input int k, input int n);
    int hi;
    hi = (s + 1) * k;
    return (hi < n) ? hi : n;
  endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One reduction level: 2^N_IN words -> 2^(N_IN-1) words under a single select bit.
// Latency: purely combinational.
// Backpressure: none, no state.
module mux_tree_level #(
  parameter int N_IN = 1,
  parameter int W    = 8
) (
  input  logic                          sel,
  input  logic [W*(2**N_IN)-1:0]        din,
  output logic [W*(2**(N_IN-1))-1:0]    dout
);

  // Pair words 2k/2k+1; sel=0 keeps the even word, sel=1 the odd one.
  always_comb begin
    dout = '0;
    for (int k = 0; k < 2**(N_IN-1); k++) begin
      dout[k*W +: W] = sel ? din[(2*k+1)*W +: W] : din[(2*k)*W +: W];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined 2^N-to-1 word selector, K tree levels per register stage, returns data + sel + one-hot.
// Latency: L = ceil(N/K) cycles from accepted input to out_valid.
// Backpressure: combinational ready chain from out_ready, each stage holds when full and blocked; no skid.
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*(2**N)-1:0]  in_data,
  input  logic [N-1:0]         in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [N-1:0]         out_sel,
  output logic [2**N-1:0]      out_onehot
);

  localparam int L = `CEIL_DIV(N, K);

  logic [L-1:0] vld;
  logic [N-1:0] sel_a [L];

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO = stage_lo(s, K);
    localparam int HI = stage_hi(s, K, N);
    localparam int NI = N - LO;          // select bits still unresolved at stage input
    localparam int NO = N - HI;          // select bits still unresolved at stage output
    localparam int OB = 1 << NO;         // words held by this stage's register

    // All intermediate word vectors of this stage, packed back to back:
    // the vector with 2^m words starts at word offset 2^m - OB.
    logic [W*((1 << (NI+1)) - OB)-1:0] chain;
    logic [W*(1 << NI)-1:0]            src_dat;
    logic [N-1:0]                      src_sel;
    logic                              src_vld;
    logic                              load;

    logic                              vld_q;
    logic [N-1:0]                      sel_q;
    logic [W*OB-1:0]                   dat_q;

    if (s == 0) begin : g_src_in
      assign src_dat = in_data;
      assign src_sel = in_sel;
      assign src_vld = in_valid;
    end else begin : g_src_prev
      assign src_dat = g_stage[s-1].dat_q;
      assign src_sel = sel_a[s-1];
      assign src_vld = vld[s-1];
    end

    // Unrolled form of "!valid_s or ready_(s+1)": the stage can move unless it and
    // every stage downstream of it is full while the consumer stalls.
    assign load = out_ready | ~(&vld[L-1:s]);

    assign chain[W*((1 << NI) - OB) +: W*(1 << NI)] = src_dat;

    for (genvar j = LO; j < HI; j++) begin : g_lvl
      localparam int M = N - j;
      mux_tree_level #(
        .N_IN (M),
        .W    (W)
      ) u_level (
        .sel  (src_sel[j]),
        .din  (chain[W*((1 << M) - OB) +: W*(1 << M)]),
        .dout (chain[W*((1 << (M-1)) - OB) +: W*(1 << (M-1))])
      );
    end

    // Stage register: take upstream data when loading; empty loads clear only the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sel_q <= '0;
        dat_q <= '0;
      end else if (load) begin
        vld_q <= src_vld;
        if (src_vld) begin
          sel_q <= src_sel;
          dat_q <= chain[0 +: W*OB];
        end
      end
    end

    assign vld[s]   = vld_q;
    assign sel_a[s] = sel_q;
  end

  assign in_ready  = out_ready | ~(&vld);
  assign out_valid = vld[L-1];
  assign out_data  = g_stage[L-1].dat_q;
  assign out_sel   = sel_a[L-1];

  // One-hot of the held select, forced to zero while no result is presented.
  always_comb begin
    out_onehot = '0;
    if (out_valid) begin
      out_onehot[out_sel] = 1'b1;
    end
  end

endmodule
